// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo is the borrow into the next bit.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, LSB first: {bout, diff} = a - b - bin over N RUN cycles.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         ready,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         bout
);

   localparam int CNT_W = cnt_w(N);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   state_t           state;
   logic [N-1:0]     a_sr;
   logic [N-1:0]     b_sr;
   logic [N-2:0]     res_sr;
   logic             br;
   logic [CNT_W-1:0] cnt;
   logic             d;
   logic             bo;
   logic [N-1:0]     res_next;

   full_subtractor u_fs (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .bi (br),
      .d  (d),
      .bo (bo)
   );

   // The final difference bit joins the N-1 already collected; it never needs storing in res_sr.
   assign res_next = {d, res_sr};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         ready  <= 1'b1;
         done   <= 1'b0;
         diff   <= '0;
         bout   <= 1'b0;
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  br    <= bin;
                  cnt   <= '0;
                  state <= RUN;
                  ready <= 1'b0;
               end else begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
            RUN: begin
               res_sr <= res_next[N-1:1];
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               br     <= bo;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= DONE;
                  ready <= 1'b1;
                  done  <= 1'b1;
                  diff  <= res_next;
                  bout  <= bo;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: driver pushes expected results, monitor checks each done.
module tb_serial_subtractor;

   localparam int N = 8;
   localparam int LAT = N + 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         bin = 1'b0;
   logic         ready;
   logic         done;
   logic [N-1:0] diff;
   logic         bout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [N:0]   sb_q[$];
   int           acc_q[$];
   logic [N-1:0] prev_diff = '0;
   logic         prev_bout = 1'b0;

   serial_subtractor #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer subtraction, borrow-out is the sign of the result.
   function automatic logic [N:0] golden(input int av, input int bv, input int bi);
      int r;
      r = av - bv - bi;
      return {(r < 0) ? 1'b1 : 1'b0, N'(r & ((1 << N) - 1))};
   endfunction

   task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi);
      int t = 0;
      @(negedge clk);
      while (!ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         errors++;
         $display("FAIL ready_timeout: ready stayed %0b, expected 1", ready);
      end
      #1;
      a = av; b = bv; bin = bi; start = 1'b1;
      sb_q.push_back(golden(av, bv, bi));
      acc_q.push_back(cyc);
      @(negedge clk);
      #1 start = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain_pending", sb_q.size(), 0);
   endtask

   // Monitor: compares every done against the scoreboard and polices output stability.
   always @(negedge clk) begin
      if (rst) begin
         check("rst_diff", diff, 0);
         check("rst_bout", bout, 0);
         check("rst_done", done, 0);
         prev_diff = '0;
         prev_bout = 1'b0;
      end else if (done) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 with no operation outstanding, diff=%0h", diff);
         end else begin
            logic [N:0] e;
            int acc;
            e = sb_q.pop_front();
            acc = acc_q.pop_front();
            check("diff", diff, e[N-1:0]);
            check("bout", bout, e[N]);
            check("latency", cyc - acc, LAT);
         end
         prev_diff = diff;
         prev_bout = bout;
      end else begin
         check("hold_diff", diff, prev_diff);
         check("hold_bout", bout, prev_bout);
      end
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      #1 rst = 1'b0;

      // Basic op, with ready low through the RUN cycles
      issue(8'd30, 8'd10, 1'b0);
      check("run_ready_c1", ready, 0);
      for (int i = 2; i <= N; i++) begin
         @(negedge clk);
         check("run_ready", ready, 0);
      end
      @(negedge clk);
      check("done_ready", ready, 1);

      // Borrow cases, then a back-to-back op issued in the DONE cycle
      issue(8'd10, 8'd20, 1'b0);
      issue(8'd0, 8'd0, 1'b1);
      issue(8'd50, 8'd40, 1'b0);
      issue(8'd77, 8'd77, 1'b0);

      // Start while busy must be ignored, including its operands
      issue(8'd100, 8'd1, 1'b0);
      @(negedge clk);
      #1 a = 8'd5; b = 8'd200; bin = 1'b1; start = 1'b1;
      @(negedge clk);
      #1 start = 1'b0;
      drain();
      repeat (12) @(negedge clk);

      // Reset during RUN cycle 4: no done, immediate return to idle outputs
      issue(8'd200, 8'd3, 1'b0);
      repeat (3) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("arst_ready", ready, 1);
      check("arst_done", done, 0);
      check("arst_diff", diff, 0);
      check("arst_bout", bout, 0);
      sb_q.delete();
      acc_q.delete();
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (12) @(negedge clk);
      issue(8'hFF, 8'h01, 1'b1);
      drain();

      // Randomized back-to-back sweep
      for (int i = 0; i < 200; i++)
         issue(N'($urandom), N'($urandom), 1'($urandom));
      drain();
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
